memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage that consumes the 106-bit execute-to-memory bus.
- Performs data-memory loads and stores, stack PUSH/POP, and the multi-word CALL/RET/RTI sequences. Owns the stack pointer and the OUT port register.
- Registers the write-back bundle into the MEM/WB boundary. The same bundle is fed back as the memory-level forwarding fields of the execute stage.
- Drives Stall upstream while a multi-cycle stack sequence is in progress.

Parameters:
- ADDR_W, 11, data-memory word-address width. SP and all memory addresses are ADDR_W bits and wrap modulo 2^ADDR_W.
- SP_RESET, 2^ADDR_W-1, stack pointer value after reset. The stack grows downward and SP points to the next free slot.

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- In  in  106  execute bus (field map below)
- Stall  out  1  upstream must hold In stable and freeze the earlier stages
- DMemAddr  out  ADDR_W  data-memory word address
- DMemWData  out  16  write data
- DMemWE  out  1  write strobe, committed on the CLK edge
- DMemRData  in  16  asynchronous read data for DMemAddr
- WbEn  out  1  registered write-back enable
- WbAddr  out  3  registered destination register
- WbVal  out  16  registered write-back value
- FwdMem  out  20  {WbEn, WbAddr, WbVal}, matching the memory-level forwarding field order
- OutPort  out  16  registered output-port value
- PcLoad  out  1  one-cycle pulse: the fetch unit loads PcValue
- PcValue  out  32  return address assembled from the stack
- FlagsLoad  out  1  one-cycle pulse: the flag register loads FlagsVal
- FlagsVal  out  3  {Z, N, C} restored by RTI

In field map:
- [105:99] flags and jump bits; not used here (consumed by the branch unit)
- [98:83] InPort
- [82:51] next-instruction address
- [50:35] Rsrc value
- [34:19] ALU result
- [18:16] Rsrc address
- [15:13] Rdst address
- [12] previous stack op, unused
- [11] PUSH
- [10] POP
- [9] RET
- [8] RTI
- [7] LDD
- [6] IN
- [5] OUT
- [4] second iteration, unused
- [3] CALL
- [2] MemRead
- [1] MemWrite
- [0] WB

Behaviour:
- Reset values:
  - SP = SP_RESET, FSM = IDLE
  - Stall, WbEn, PcLoad, FlagsLoad, DMemWE = 0
  - WbAddr, WbVal, OutPort, PcValue, FlagsVal = 0
- Control sampling and priority:
  - Controls are sampled only in IDLE.
  - Priority when several are set: RTI > RET > CALL > POP > PUSH > LDD/STD > plain.
- Single-cycle operations (Stall = 0; results appear on the WB outputs one cycle later):
  - Plain: WbVal = ALU result.
  - IN: WbVal = InPort.
  - OUT: OutPort <= ALU result.
  - LDD (MemRead & LDD): DMemAddr = ALU[ADDR_W-1:0]; WbVal = DMemRData.
  - STD (MemWrite, no stack op): DMemAddr = ALU; DMemWData = Rsrc value; DMemWE = 1.
  - PUSH: mem[SP] <= Rsrc value; SP <= SP-1.
  - POP: DMemAddr = SP+1; WbVal = DMemRData; SP <= SP+1.
  - WbEn <= In[0] and WbAddr <= Rdst address on every completed instruction. WbEn = 0 during non-final sequence cycles.
- CALL (2 cycles):
  - IDLE: mem[SP] <= addr[31:16]; Stall = 1; go to S1.
  - S1: mem[SP-1] <= addr[15:0]; SP <= SP-2; Stall = 0; go to IDLE.
- RET (2 cycles):
  - IDLE: read SP+1, latch low half; Stall = 1; go to S1.
  - S1: read SP+2; PcValue <= {rdata, low}; PcLoad pulses next cycle; SP <= SP+2; go to IDLE.
- RTI (3 cycles):
  - Same as RET with S1 non-final; go to S2.
  - S2: read SP+3; FlagsVal <= rdata[2:0]; FlagsLoad and PcLoad pulse together; SP <= SP+3.
- Stall is combinational: high in IDLE when CALL/RET/RTI is decoded, and in every non-final state.
- DMemWE is never asserted for reads. DMemAddr is don't-care when no access is made.
- Wrap-around: SP increments and decrements wrap silently. There is no overflow or underflow flag.
- Reset mid-sequence: FSM returns to IDLE and SP = SP_RESET. Words already written stay in memory. No PcLoad or FlagsLoad is emitted.
- Forwarding: FwdMem is purely the registered WB bundle, with zero added latency.

Decomposition:
- Shared package:
  - bit-position constants for the 106-bit bus fields
  - FSM state encoding (IDLE, S1, S2)
  - SP_RESET default
- One natural sub-module, stack_sequencer: the FSM, SP register, PcValue/FlagsVal assembly, and Stall.
- memory_stage keeps the address/data muxing and the WB/OUT registers.

Test Plan:
- After reset, plain ALU op with ALU = 0x1234, Rdst = 5, WB = 1 -> next cycle WbEn = 1, WbAddr = 5, WbVal = 0x1234, FwdMem = {1, 5, 0x1234}.
- STD (ALU = 0x0010, Rsrc = 0xBEEF) then LDD (ALU = 0x0010, Rdst = 2) -> WbVal = 0xBEEF, WbAddr = 2.
- PUSH 0xAAAA, PUSH 0x5555, then POP, POP with ADDR_W = 11 -> SP goes 0x7FF, 0x7FE, 0x7FD, then back to 0x7FF; POP values are 0x5555 then 0xAAAA.
- CALL with addr = 0x0001_0200, then RET -> Stall high exactly 1 cycle each; PcValue = 0x0001_0200 with a single PcLoad pulse; SP back to 0x7FF.
- Preloaded stack {flags 0b101, PC 0x0000_0040} then RTI -> Stall high for 2 cycles; FlagsLoad and PcLoad pulse together with FlagsVal = 0b101, PcValue = 0x40; SP += 3.
- Reset asserted in S1 of CALL -> IDLE next cycle, Stall = 0, SP = SP_RESET, no PcLoad. Also SP = 0 then PUSH -> SP wraps to 0x7FF.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: execute-bus field positions,
// stack-sequencer state encoding and operation classes.
package memory_stage_pkg;

  localparam int unsigned BUS_W      = 106;
  localparam int unsigned ADDR_W_DEF = 11;

  localparam int unsigned B_WB       = 0;
  localparam int unsigned B_MEMWRITE = 1;
  localparam int unsigned B_MEMREAD  = 2;
  localparam int unsigned B_CALL     = 3;
  localparam int unsigned B_SECOND   = 4;
  localparam int unsigned B_OUT      = 5;
  localparam int unsigned B_IN       = 6;
  localparam int unsigned B_LDD      = 7;
  localparam int unsigned B_RTI      = 8;
  localparam int unsigned B_RET      = 9;
  localparam int unsigned B_POP      = 10;
  localparam int unsigned B_PUSH     = 11;
  localparam int unsigned B_PREV     = 12;

  localparam int unsigned RDST_LSB   = 13;
  localparam int unsigned RSRCA_LSB  = 16;
  localparam int unsigned ALU_LSB    = 19;
  localparam int unsigned RSRC_LSB   = 35;
  localparam int unsigned NEXT_LSB   = 51;
  localparam int unsigned INPORT_LSB = 83;
  localparam int unsigned FLAGS_LSB  = 99;

  typedef enum logic [1:0] {IDLE, S1, S2} state_e;

  typedef enum logic [1:0] {OP_CALL, OP_RET, OP_RTI} seq_op_e;

  typedef enum logic [2:0] {
    CLS_PLAIN, CLS_STD, CLS_LDD, CLS_PUSH, CLS_POP, CLS_CALL, CLS_RET, CLS_RTI
  } op_class_e;

  function automatic int unsigned sp_reset_default(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

  // Resolves simultaneous control bits to a single operation by priority.
  function automatic op_class_e decode_class(
    input logic rti, input logic ret, input logic call, input logic pop,
    input logic push, input logic mem_read, input logic ldd, input logic mem_write);
    if (rti)                  return CLS_RTI;
    else if (ret)             return CLS_RET;
    else if (call)            return CLS_CALL;
    else if (pop)             return CLS_POP;
    else if (push)            return CLS_PUSH;
    else if (mem_read && ldd) return CLS_LDD;
    else if (mem_write)       return CLS_STD;
    else                      return CLS_PLAIN;
  endfunction

endpackage

// File: rtl/memory_stage_stack_sequencer.sv
// Stack pointer and CALL/RET/RTI sequencing FSM; assembles the return
// address and restored flags from words read off the stack.
module memory_stage_stack_sequencer
  import memory_stage_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned SP_RESET = sp_reset_default(ADDR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  op_class_e         cls,
  input  logic [15:0]       rdata,
  output state_e            state,
  output seq_op_e           op,
  output logic [ADDR_W-1:0] sp,
  output logic              stall_c,
  output logic              pc_load,
  output logic [31:0]       pc_value,
  output logic              flags_load,
  output logic [2:0]        flags_val
);

  state_e            state_n;
  seq_op_e           op_n;
  logic [ADDR_W-1:0] sp_n;
  logic [15:0]       lo, lo_n, hi, hi_n;
  logic              pc_load_n, flags_load_n;
  logic [31:0]       pc_value_n;
  logic [2:0]        flags_val_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op         <= OP_CALL;
      sp         <= ADDR_W'(SP_RESET);
      lo         <= 16'h0000;
      hi         <= 16'h0000;
      pc_load    <= 1'b0;
      pc_value   <= 32'h0000_0000;
      flags_load <= 1'b0;
      flags_val  <= 3'b000;
    end else begin
      state      <= state_n;
      op         <= op_n;
      sp         <= sp_n;
      lo         <= lo_n;
      hi         <= hi_n;
      pc_load    <= pc_load_n;
      pc_value   <= pc_value_n;
      flags_load <= flags_load_n;
      flags_val  <= flags_val_n;
    end
  end

  // Next state, SP update and return-value assembly; stall marks non-final cycles.
  always_comb begin
    state_n      = state;
    op_n         = op;
    sp_n         = sp;
    lo_n         = lo;
    hi_n         = hi;
    pc_load_n    = 1'b0;
    pc_value_n   = pc_value;
    flags_load_n = 1'b0;
    flags_val_n  = flags_val;
    stall_c      = 1'b0;
    case (state)
      IDLE: begin
        case (cls)
          CLS_RTI: begin
            op_n = OP_RTI; lo_n = rdata; stall_c = 1'b1; state_n = S1;
          end
          CLS_RET: begin
            op_n = OP_RET; lo_n = rdata; stall_c = 1'b1; state_n = S1;
          end
          CLS_CALL: begin
            op_n = OP_CALL; stall_c = 1'b1; state_n = S1;
          end
          CLS_POP:  sp_n = sp + ADDR_W'(1);
          CLS_PUSH: sp_n = sp - ADDR_W'(1);
          default: ;
        endcase
      end
      S1: begin
        case (op)
          OP_CALL: begin
            sp_n    = sp - ADDR_W'(2);
            state_n = IDLE;
          end
          OP_RET: begin
            pc_value_n = {rdata, lo};
            pc_load_n  = 1'b1;
            sp_n       = sp + ADDR_W'(2);
            state_n    = IDLE;
          end
          OP_RTI: begin
            hi_n    = rdata;
            stall_c = 1'b1;
            state_n = S2;
          end
          default: state_n = IDLE;
        endcase
      end
      S2: begin
        flags_val_n  = rdata[2:0];
        pc_value_n   = {hi, lo};
        flags_load_n = 1'b1;
        pc_load_n    = 1'b1;
        sp_n         = sp + ADDR_W'(3);
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: data-memory access muxing, stack operations via the
// sequencer, and the registered MEM/WB bundle and output port.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned SP_RESET = sp_reset_default(ADDR_W)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [BUS_W-1:0]  In,
  output logic              Stall,
  output logic [ADDR_W-1:0] DMemAddr,
  output logic [15:0]       DMemWData,
  output logic              DMemWE,
  input  logic [15:0]       DMemRData,
  output logic              WbEn,
  output logic [2:0]        WbAddr,
  output logic [15:0]       WbVal,
  output logic [19:0]       FwdMem,
  output logic [15:0]       OutPort,
  output logic              PcLoad,
  output logic [31:0]       PcValue,
  output logic              FlagsLoad,
  output logic [2:0]        FlagsVal
);

  logic [15:0]       alu, rsrc, inport, wb_val_c;
  logic [31:0]       next_addr;
  logic [2:0]        rdst;
  logic              we_c;
  logic              unused_bits;
  op_class_e         cls;
  state_e            state;
  seq_op_e           op;
  logic [ADDR_W-1:0] sp;

  assign alu       = In[ALU_LSB +: 16];
  assign rsrc      = In[RSRC_LSB +: 16];
  assign inport    = In[INPORT_LSB +: 16];
  assign next_addr = In[NEXT_LSB +: 32];
  assign rdst      = In[RDST_LSB +: 3];
  assign unused_bits = ^{In[BUS_W-1:FLAGS_LSB], In[RSRCA_LSB +: 3], In[B_PREV], In[B_SECOND]};

  assign cls = decode_class(In[B_RTI], In[B_RET], In[B_CALL], In[B_POP], In[B_PUSH],
                            In[B_MEMREAD], In[B_LDD], In[B_MEMWRITE]);

  memory_stage_stack_sequencer #(
    .ADDR_W  (ADDR_W),
    .SP_RESET(SP_RESET)
  ) u_seq (
    .clk       (CLK),
    .reset     (Reset),
    .cls       (cls),
    .rdata     (DMemRData),
    .state     (state),
    .op        (op),
    .sp        (sp),
    .stall_c   (Stall),
    .pc_load   (PcLoad),
    .pc_value  (PcValue),
    .flags_load(FlagsLoad),
    .flags_val (FlagsVal)
  );

  // Address/data selection for the current cycle of the active operation.
  always_comb begin
    DMemAddr  = alu[ADDR_W-1:0];
    DMemWData = rsrc;
    we_c      = 1'b0;
    case (state)
      IDLE: begin
        case (cls)
          CLS_RTI, CLS_RET, CLS_POP: DMemAddr = sp + ADDR_W'(1);
          CLS_CALL: begin
            DMemAddr  = sp;
            DMemWData = next_addr[31:16];
            we_c      = 1'b1;
          end
          CLS_PUSH: begin
            DMemAddr = sp;
            we_c     = 1'b1;
          end
          CLS_STD: we_c = 1'b1;
          default: ;
        endcase
      end
      S1: begin
        if (op == OP_CALL) begin
          DMemAddr  = sp - ADDR_W'(1);
          DMemWData = next_addr[15:0];
          we_c      = 1'b1;
        end else begin
          DMemAddr = sp + ADDR_W'(2);
        end
      end
      S2:      DMemAddr = sp + ADDR_W'(3);
      default: ;
    endcase
  end

  // Writes are suppressed while reset is held so a reset mid-sequence leaves memory alone.
  assign DMemWE = we_c & ~Reset;

  always_comb begin
    wb_val_c = alu;
    if (state == IDLE) begin
      if (cls == CLS_POP || cls == CLS_LDD)   wb_val_c = DMemRData;
      else if (cls == CLS_PLAIN && In[B_IN]) wb_val_c = inport;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      WbEn    <= 1'b0;
      WbAddr  <= 3'd0;
      WbVal   <= 16'h0000;
      OutPort <= 16'h0000;
    end else begin
      WbEn <= In[B_WB] & ~Stall;
      if (!Stall) begin
        WbAddr <= rdst;
        WbVal  <= wb_val_c;
      end
      if (state == IDLE && cls == CLS_PLAIN && In[B_OUT]) OutPort <= alu;
    end
  end

  assign FwdMem = {WbEn, WbAddr, WbVal};

endmodule

// File: tb/tb_memory_stage.sv
// Directed table-driven bench for memory_stage with a behavioural data memory.
module tb_memory_stage;

  localparam logic [12:0] C_WB   = 13'h001;
  localparam logic [12:0] C_MW   = 13'h002;
  localparam logic [12:0] C_MR   = 13'h004;
  localparam logic [12:0] C_CALL = 13'h008;
  localparam logic [12:0] C_OUT  = 13'h020;
  localparam logic [12:0] C_IN   = 13'h040;
  localparam logic [12:0] C_LDD  = 13'h080;
  localparam logic [12:0] C_RTI  = 13'h100;
  localparam logic [12:0] C_RET  = 13'h200;
  localparam logic [12:0] C_POP  = 13'h400;
  localparam logic [12:0] C_PUSH = 13'h800;

  logic         CLK, Reset;
  logic [105:0] In;
  logic         Stall, DMemWE, WbEn, PcLoad, FlagsLoad;
  logic [10:0]  DMemAddr;
  logic [15:0]  DMemWData, DMemRData, WbVal, OutPort;
  logic [2:0]   WbAddr, FlagsVal;
  logic [19:0]  FwdMem;
  logic [31:0]  PcValue;
  logic [15:0]  mem [0:2047];

  int n_cmp  = 0;
  int n_fail = 0;

  memory_stage dut (
    .CLK(CLK), .Reset(Reset), .In(In), .Stall(Stall),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemWE(DMemWE), .DMemRData(DMemRData),
    .WbEn(WbEn), .WbAddr(WbAddr), .WbVal(WbVal), .FwdMem(FwdMem), .OutPort(OutPort),
    .PcLoad(PcLoad), .PcValue(PcValue), .FlagsLoad(FlagsLoad), .FlagsVal(FlagsVal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) if (DMemWE) mem[DMemAddr] <= DMemWData;
  assign DMemRData = mem[DMemAddr];

  typedef struct {
    string       name;
    logic [12:0] ctrl;
    logic [2:0]  rdst;
    logic [15:0] alu, rsrc, inport;
    logic        exp_we, chk_addr;
    logic [10:0] exp_addr;
    logic        exp_wben;
    logic [15:0] exp_wbval, exp_out;
    logic [10:0] exp_sp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(string name, logic [12:0] ctrl, logic [2:0] rdst,
      logic [15:0] alu, logic [15:0] rsrc, logic [15:0] inport, logic exp_we,
      logic chk_addr, logic [10:0] exp_addr, logic exp_wben, logic [15:0] exp_wbval,
      logic [15:0] exp_out, logic [10:0] exp_sp);
    vec_t v;
    v.name = name; v.ctrl = ctrl; v.rdst = rdst; v.alu = alu; v.rsrc = rsrc;
    v.inport = inport; v.exp_we = exp_we; v.chk_addr = chk_addr; v.exp_addr = exp_addr;
    v.exp_wben = exp_wben; v.exp_wbval = exp_wbval; v.exp_out = exp_out; v.exp_sp = exp_sp;
    return v;
  endfunction

  function automatic logic [105:0] mk_bus(logic [12:0] ctrl, logic [2:0] rdst,
      logic [15:0] alu, logic [15:0] rsrc, logic [15:0] inport, logic [31:0] nxt);
    logic [105:0] b;
    b = '0;
    b[12:0]   = ctrl;
    b[15:13]  = rdst;
    b[18:16]  = 3'd6;
    b[34:19]  = alu;
    b[50:35]  = rsrc;
    b[82:51]  = nxt;
    b[98:83]  = inport;
    b[105:99] = 7'h55;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [12:0] ctrl, input logic [2:0] rdst, input logic [15:0] alu,
                       input logic [15:0] rsrc, input logic [15:0] inport, input logic [31:0] nxt);
    @(negedge CLK);
    In = mk_bus(ctrl, rdst, alu, rsrc, inport, nxt);
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    In    = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.stall", 32'(Stall), 0);
    chk("rst.wben", 32'(WbEn), 0);
    chk("rst.wbaddr", 32'(WbAddr), 0);
    chk("rst.wbval", 32'(WbVal), 0);
    chk("rst.out", 32'(OutPort), 0);
    chk("rst.pcval", PcValue, 0);
    chk("rst.flagsval", 32'(FlagsVal), 0);
    chk("rst.pcload", 32'(PcLoad), 0);
    chk("rst.flagsload", 32'(FlagsLoad), 0);
    chk("rst.sp", 32'(dut.u_seq.sp), 32'h7FF);
    @(negedge CLK);
    Reset = 1'b0;

    // Single-cycle operations
    vq.push_back(mkv("plain", C_WB, 3'd5, 16'h1234, 16'h0, 16'h0, 0, 0, 11'h0, 1, 16'h1234, 16'h0, 11'h7FF));
    vq.push_back(mkv("std", C_MW, 3'd0, 16'h0010, 16'hBEEF, 16'h0, 1, 1, 11'h010, 0, 16'h0, 16'h0, 11'h7FF));
    vq.push_back(mkv("ldd", C_MR | C_LDD | C_WB, 3'd2, 16'h0010, 16'h0, 16'h0, 0, 1, 11'h010, 1, 16'hBEEF, 16'h0, 11'h7FF));
    vq.push_back(mkv("in", C_IN | C_WB, 3'd3, 16'h1111, 16'h0, 16'h5A5A, 0, 0, 11'h0, 1, 16'h5A5A, 16'h0, 11'h7FF));
    vq.push_back(mkv("out", C_OUT, 3'd1, 16'hC0DE, 16'h0, 16'h0, 0, 0, 11'h0, 0, 16'h0, 16'hC0DE, 11'h7FF));
    vq.push_back(mkv("push1", C_PUSH | C_MW, 3'd0, 16'h0, 16'hAAAA, 16'h0, 1, 1, 11'h7FF, 0, 16'h0, 16'hC0DE, 11'h7FE));
    vq.push_back(mkv("push2", C_PUSH | C_MW, 3'd0, 16'h0, 16'h5555, 16'h0, 1, 1, 11'h7FE, 0, 16'h0, 16'hC0DE, 11'h7FD));
    vq.push_back(mkv("pop1", C_POP | C_MR | C_WB, 3'd4, 16'h0, 16'h0, 16'h0, 0, 1, 11'h7FE, 1, 16'h5555, 16'hC0DE, 11'h7FE));
    vq.push_back(mkv("pop2", C_POP | C_MR | C_WB, 3'd6, 16'h0, 16'h0, 16'h0, 0, 1, 11'h7FF, 1, 16'hAAAA, 16'hC0DE, 11'h7FF));

    foreach (vq[i]) begin
      drive(vq[i].ctrl, vq[i].rdst, vq[i].alu, vq[i].rsrc, vq[i].inport, 32'h0);
      chk({vq[i].name, ".stall"}, 32'(Stall), 0);
      chk({vq[i].name, ".we"}, 32'(DMemWE), 32'(vq[i].exp_we));
      if (vq[i].chk_addr) chk({vq[i].name, ".addr"}, 32'(DMemAddr), 32'(vq[i].exp_addr));
      if (vq[i].exp_we) chk({vq[i].name, ".wdata"}, 32'(DMemWData), 32'(vq[i].rsrc));
      tick();
      chk({vq[i].name, ".wben"}, 32'(WbEn), 32'(vq[i].exp_wben));
      chk({vq[i].name, ".wbaddr"}, 32'(WbAddr), 32'(vq[i].rdst));
      if (vq[i].exp_wben) begin
        chk({vq[i].name, ".wbval"}, 32'(WbVal), 32'(vq[i].exp_wbval));
        chk({vq[i].name, ".fwd"}, 32'(FwdMem), 32'({1'b1, vq[i].rdst, vq[i].exp_wbval}));
      end
      chk({vq[i].name, ".out"}, 32'(OutPort), 32'(vq[i].exp_out));
      chk({vq[i].name, ".sp"}, 32'(dut.u_seq.sp), 32'(vq[i].exp_sp));
    end

    // CALL 0x0001_0200 then RET
    drive(C_CALL, 3'd0, 16'h0, 16'h0, 16'h0, 32'h0001_0200);
    chk("call0.stall", 32'(Stall), 1);
    chk("call0.we", 32'(DMemWE), 1);
    chk("call0.addr", 32'(DMemAddr), 32'h7FF);
    chk("call0.wdata", 32'(DMemWData), 32'h0001);
    tick();
    chk("call0.wben", 32'(WbEn), 0);
    chk("call1.stall", 32'(Stall), 0);
    chk("call1.we", 32'(DMemWE), 1);
    chk("call1.addr", 32'(DMemAddr), 32'h7FE);
    chk("call1.wdata", 32'(DMemWData), 32'h0200);
    tick();
    chk("call.sp", 32'(dut.u_seq.sp), 32'h7FD);
    drive(C_RET, 3'd0, 16'h0, 16'h0, 16'h0, 32'h0);
    chk("ret0.stall", 32'(Stall), 1);
    chk("ret0.we", 32'(DMemWE), 0);
    chk("ret0.addr", 32'(DMemAddr), 32'h7FE);
    tick();
    chk("ret0.pcload", 32'(PcLoad), 0);
    chk("ret1.stall", 32'(Stall), 0);
    chk("ret1.addr", 32'(DMemAddr), 32'h7FF);
    tick();
    chk("ret.pcload", 32'(PcLoad), 1);
    chk("ret.pcval", PcValue, 32'h0001_0200);
    chk("ret.flagsload", 32'(FlagsLoad), 0);
    chk("ret.sp", 32'(dut.u_seq.sp), 32'h7FF);
    drive(13'h0, 3'd0, 16'h0, 16'h0, 16'h0, 32'h0);
    tick();
    chk("ret.pcload_drop", 32'(PcLoad), 0);

    // Stack preloaded with flags 0b101 and PC 0x40, then RTI
    drive(C_PUSH | C_MW, 3'd0, 16'h0, 16'h0005, 16'h0, 32'h0);
    tick();
    drive(C_CALL, 3'd0, 16'h0, 16'h0, 16'h0, 32'h0000_0040);
    tick();
    tick();
    chk("pre.sp", 32'(dut.u_seq.sp), 32'h7FC);
    drive(C_RTI, 3'd0, 16'h0, 16'h0, 16'h0, 32'h0);
    chk("rti0.stall", 32'(Stall), 1);
    chk("rti0.addr", 32'(DMemAddr), 32'h7FD);
    tick();
    chk("rti1.stall", 32'(Stall), 1);
    chk("rti1.addr", 32'(DMemAddr), 32'h7FE);
    chk("rti1.pcload", 32'(PcLoad), 0);
    tick();
    chk("rti2.stall", 32'(Stall), 0);
    chk("rti2.addr", 32'(DMemAddr), 32'h7FF);
    chk("rti2.we", 32'(DMemWE), 0);
    chk("rti2.loads", 32'({PcLoad, FlagsLoad}), 0);
    tick();
    chk("rti.loads", 32'({PcLoad, FlagsLoad}), 32'h3);
    chk("rti.flagsval", 32'(FlagsVal), 32'h5);
    chk("rti.pcval", PcValue, 32'h0000_0040);
    chk("rti.sp", 32'(dut.u_seq.sp), 32'h7FF);
    drive(13'h0, 3'd0, 16'h0, 16'h0, 16'h0, 32'h0);
    tick();
    chk("rti.loads_drop", 32'({PcLoad, FlagsLoad}), 0);

    // Reset asserted in S1 of a CALL
    drive(C_PUSH | C_MW, 3'd0, 16'h0, 16'h1111, 16'h0, 32'h0);
    tick();
    drive(C_CALL, 3'd0, 16'h0, 16'h0, 16'h0, 32'h0000_1234);
    chk("rcall0.stall", 32'(Stall), 1);
    tick();
    chk("rcall1.we", 32'(DMemWE), 1);
    chk("rcall1.addr", 32'(DMemAddr), 32'h7FD);
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    In = mk_bus(C_WB, 3'd7, 16'hABCD, 16'h0, 16'h0, 32'h0);
    #1;
    chk("rst_mid.sp", 32'(dut.u_seq.sp), 32'h7FF);
    chk("rst_mid.stall", 32'(Stall), 0);
    chk("rst_mid.we", 32'(DMemWE), 0);
    chk("rst_mid.pcload", 32'(PcLoad), 0);
    tick();
    chk("rst_mid.wbval", 32'(WbVal), 32'hABCD);
    chk("rst_mid.pcload2", 32'(PcLoad), 0);

    // SP wrap: POP at 0x7FF reads address 0, then PUSH at 0 wraps back
    drive(C_POP | C_MR | C_WB, 3'd1, 16'h0, 16'h0, 16'h0, 32'h0);
    chk("wrap_pop.addr", 32'(DMemAddr), 32'h000);
    tick();
    chk("wrap_pop.sp", 32'(dut.u_seq.sp), 32'h000);
    drive(C_PUSH | C_MW, 3'd0, 16'h0, 16'h7777, 16'h0, 32'h0);
    chk("wrap_push.addr", 32'(DMemAddr), 32'h000);
    chk("wrap_push.we", 32'(DMemWE), 1);
    tick();
    chk("wrap_push.sp", 32'(dut.u_seq.sp), 32'h7FF);
    drive(C_POP | C_MR | C_WB, 3'd2, 16'h0, 16'h0, 16'h0, 32'h0);
    tick();
    chk("wrap_pop2.wbval", 32'(WbVal), 32'h7777);
    chk("wrap_pop2.sp", 32'(dut.u_seq.sp), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
